// File: rtl/uart_mem_if.sv
// UART-to-text-RAM bridge: turns received bytes into character writes on an
// 80x30 text buffer, tracking a cursor and handling CR, LF, BS and FF (clear).
module uart_mem_if (
   input  logic        clock100,
   input  logic        reset,
   input  logic [7:0]  data_in,
   input  logic        data_ready,
   output logic [7:0]  data_out,
   output logic [11:0] wraddress,
   output logic        wren
);

   localparam logic [6:0]  LAST_COL  = 7'd79;
   localparam logic [4:0]  LAST_ROW  = 5'd29;
   localparam logic [11:0] LAST_ADDR = 12'd2399;
   localparam logic [11:0] ROW_STEP  = 12'd80;

   localparam logic [7:0]  CH_BS     = 8'h08;
   localparam logic [7:0]  CH_LF     = 8'h0A;
   localparam logic [7:0]  CH_FF     = 8'h0C;
   localparam logic [7:0]  CH_CR     = 8'h0D;
   localparam logic [7:0]  CH_SPACE  = 8'h20;
   localparam logic [7:0]  CH_TILDE  = 8'h7E;

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   state_t      state_q, state_d;
   logic        ready_q, ready_d;
   logic [6:0]  col_q,   col_d;
   logic [4:0]  row_q,   row_d;
   logic [11:0] addr_q,  addr_d;
   logic [11:0] clr_q,   clr_d;
   logic        wren_q,  wren_d;
   logic [7:0]  data_q,  data_d;
   logic [11:0] waddr_q, waddr_d;

   logic        accept;
   logic        printable;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d   = state_q;
      ready_d   = data_ready;
      col_d     = col_q;
      row_d     = row_q;
      addr_d    = addr_q;
      clr_d     = clr_q;
      wren_d    = 1'b0;
      data_d    = data_q;
      waddr_d   = waddr_q;

      accept    = data_ready && !ready_q;
      printable = (data_in >= CH_SPACE) && (data_in <= CH_TILDE);

      case (state_q)
         ST_IDLE: begin
            if (accept && printable) begin
               wren_d  = 1'b1;
               data_d  = data_in;
               waddr_d = addr_q;
               if (col_q == LAST_COL) begin
                  col_d = 7'd0;
                  row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
               end else begin
                  col_d = col_q + 7'd1;
               end
               addr_d = (addr_q == LAST_ADDR) ? 12'd0 : addr_q + 12'd1;
            end else if (accept) begin
               case (data_in)
                  CH_CR: begin
                     col_d  = 7'd0;
                     addr_d = addr_q - {5'd0, col_q};
                  end
                  CH_LF: begin
                     col_d = 7'd0;
                     if (row_q == LAST_ROW) begin
                        row_d  = 5'd0;
                        addr_d = 12'd0;
                     end else begin
                        row_d  = row_q + 5'd1;
                        addr_d = addr_q - {5'd0, col_q} + ROW_STEP;
                     end
                  end
                  CH_BS: begin
                     // Backspace at the home cell blanks it in place.
                     wren_d = 1'b1;
                     data_d = CH_SPACE;
                     if (addr_q != 12'd0) begin
                        if (col_q == 7'd0) begin
                           col_d = LAST_COL;
                           row_d = row_q - 5'd1;
                        end else begin
                           col_d = col_q - 7'd1;
                        end
                        addr_d  = addr_q - 12'd1;
                        waddr_d = addr_q - 12'd1;
                     end else begin
                        waddr_d = 12'd0;
                     end
                  end
                  CH_FF: begin
                     state_d = ST_CLEAR;
                     wren_d  = 1'b1;
                     data_d  = CH_SPACE;
                     waddr_d = 12'd0;
                     clr_d   = 12'd1;
                     col_d   = 7'd0;
                     row_d   = 5'd0;
                     addr_d  = 12'd0;
                  end
                  default: begin
                  end
               endcase
            end
         end

         ST_CLEAR: begin
            // Accepted edges are consumed by ready_q tracking, so they are dropped.
            wren_d  = 1'b1;
            data_d  = CH_SPACE;
            waddr_d = clr_q;
            if (clr_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               clr_d   = 12'd0;
            end else begin
               clr_d   = clr_q + 12'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock100) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         col_q   <= 7'd0;
         row_q   <= 5'd0;
         addr_q  <= 12'd0;
         clr_q   <= 12'd0;
         wren_q  <= 1'b0;
         data_q  <= 8'h00;
         waddr_q <= 12'd0;
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
         col_q   <= col_d;
         row_q   <= row_d;
         addr_q  <= addr_d;
         clr_q   <= clr_d;
         wren_q  <= wren_d;
         data_q  <= data_d;
         waddr_q <= waddr_d;
      end
   end

   assign wren      = wren_q;
   assign data_out  = data_q;
   assign wraddress = waddr_q;

endmodule

// File: tb/tb_uart_mem_if.sv
// Directed bench for uart_mem_if: expected writes are queued as bytes are
// driven and compared against every wren pulse on the falling clock edge.
module tb_uart_mem_if;

   typedef struct packed {
      logic [11:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk;
   logic        reset;
   logic [7:0]  data_in;
   logic        data_ready;
   logic [7:0]  data_out;
   logic [11:0] wraddress;
   logic        wren;

   wr_t sb[$];
   int  tests = 0;
   int  fails = 0;

   uart_mem_if dut (
      .clock100   (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_ready (data_ready),
      .data_out   (data_out),
      .wraddress  (wraddress),
      .wren       (wren)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_wr(input int addr, input logic [7:0] data);
      wr_t e;
      e.addr = 12'(addr);
      e.data = data;
      sb.push_back(e);
   endtask

   // One-cycle data_ready pulse, then settle and confirm all expected writes arrived.
   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      data_in    = b;
      data_ready = 1'b1;
      @(posedge clk); #1;
      data_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("pending_writes", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (wren === 1'b1) begin
         check("write_expected", (sb.size() > 0) ? 1 : 0, 1);
         if (sb.size() > 0) begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(wraddress), 32'(e.addr));
            check("wr_data", 32'(data_out), 32'(e.data));
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gaps;

      reset      = 1'b1;
      data_in    = 8'h00;
      data_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_wren", 32'(wren), 0);
      check("reset_data", 32'(data_out), 0);
      check("reset_addr", 32'(wraddress), 0);
      reset = 1'b0;

      // Back-to-back bytes at minimum spacing.
      expect_wr(0, 8'h40);
      expect_wr(1, 8'h41);
      @(posedge clk); #1;
      data_in = 8'h40; data_ready = 1'b1;
      @(posedge clk); #1;
      data_ready = 1'b0;
      @(posedge clk); #1;
      data_in = 8'h41; data_ready = 1'b1;
      @(posedge clk); #1;
      data_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("b2b_pending", sb.size(), 0);

      // Long-high data_ready yields one write; later data_in changes are ignored.
      expect_wr(2, 8'h42);
      @(posedge clk); #1;
      data_in = 8'h42; data_ready = 1'b1;
      @(posedge clk); #1;
      data_in = 8'h55;
      repeat (9) @(posedge clk);
      #1 data_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 check("hold_pending", sb.size(), 0);

      // CR back to 0, fill row 0, then X/CR/Y/LF/Z.
      send(8'h0D);
      for (int i = 0; i < 80; i++) begin
         expect_wr(i, 8'(8'h21 + (i % 90)));
         send(8'(8'h21 + (i % 90)));
      end
      expect_wr(80, "X");  send("X");
      send(8'h0D);
      expect_wr(80, "Y");  send("Y");
      send(8'h0A);
      expect_wr(160, "Z"); send("Z");

      // Ignored bytes produce no write.
      send(8'h07);
      send(8'h80);
      send(8'h00);
      send(8'hFF);
      send(8'h7F);

      // Backspace within a row, across a row boundary, then from address 80.
      expect_wr(160, 8'h20); send(8'h08);
      expect_wr(159, 8'h20); send(8'h08);
      send(8'h0D);
      expect_wr(79, 8'h20);  send(8'h08);

      // Walk to the last cell and wrap.
      send(8'h0D);
      for (int i = 0; i < 29; i++) send(8'h0A);
      for (int i = 0; i < 79; i++) begin
         expect_wr(2320 + i, 8'h61);
         send(8'h61);
      end
      expect_wr(2399, "A"); send("A");
      expect_wr(0, "B");    send("B");
      expect_wr(0, 8'h20);  send(8'h08);
      expect_wr(0, 8'h20);  send(8'h08);
      expect_wr(0, "C");    send("C");

      // Thirty line feeds wrap the row back to 0.
      for (int i = 0; i < 30; i++) send(8'h0A);
      expect_wr(0, "D");    send("D");

      // Full clear with a dropped byte mid-sequence.
      for (int i = 0; i < 2400; i++) expect_wr(i, 8'h20);
      @(posedge clk); #1;
      data_in = 8'h0C; data_ready = 1'b1;
      @(posedge clk); #1;
      data_ready = 1'b0;
      gaps = 0;
      for (int i = 0; i < 2400; i++) begin
         @(negedge clk);
         if (wren !== 1'b1) gaps++;
         if (i == 500) begin
            data_in    = "Q";
            data_ready = 1'b1;
         end
         if (i == 503) data_ready = 1'b0;
      end
      @(posedge clk); #1;
      check("clear_gaps", gaps, 0);
      check("clear_pending", sb.size(), 0);
      @(negedge clk);
      check("clear_end_wren", 32'(wren), 0);
      expect_wr(0, "E"); send("E");

      // Reset in the middle of a clear.
      for (int i = 0; i < 2400; i++) expect_wr(i, 8'h20);
      @(posedge clk); #1;
      data_in = 8'h0C; data_ready = 1'b1;
      @(posedge clk); #1;
      data_ready = 1'b0;
      repeat (300) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("midclr_reset_wren", 32'(wren), 0);
      check("midclr_reset_addr", 32'(wraddress), 0);
      sb.delete();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("midclr_idle_wren", 32'(wren), 0);
      expect_wr(0, "F"); send("F");
      send(8'h07);
      send(8'h80);
      repeat (5) @(posedge clk);
      #1 check("final_pending", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
